desc_builder: RTL and testbench

Sits directly downstream of header_parser on the same ingress AXI stream. On each packet's first beat it drives desc_req/desc_next to the parser and latches the parser's combinational descriptor fields. It writes the packet into a ring packet buffer and measures the byte length. On tlast it pushes a completed descriptor (parser fields, buffer address, measured length, flags) into a descriptor FIFO drained by the scheduler over a valid/ready port.

---
 rtl/desc_builder.sv | 191 +++++++++++++++++++
 tb/tb_desc_builder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/desc_builder.sv
// Descriptor builder: admits ingress packets into a ring packet buffer, measures their length,
// and queues one descriptor per stored packet for the scheduler over a valid/ready port.
module desc_builder #(
    parameter int DATA_WIDTH    = 256,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int PRIO_W        = 8,
    parameter int CHAIN_W       = 32,
    parameter int TIME_W        = 16,
    parameter int LEN_W         = 16,
    parameter int FLOW_W        = 8,
    parameter int BUF_AW        = 10,
    parameter int MAX_PKT_WORDS = 64,
    parameter int DESC_DEPTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic                    desc_req,
    output logic                    desc_next,
    input  logic [PRIO_W-1:0]       p_desc_prio,
    input  logic [CHAIN_W-1:0]      p_desc_chain,
    input  logic [TIME_W-1:0]       p_desc_time,
    input  logic [LEN_W-1:0]        p_desc_pk_len,
    input  logic [FLOW_W-1:0]       p_desc_flow_id,
    output logic                    buf_wr_en,
    output logic [BUF_AW-1:0]       buf_wr_addr,
    output logic [DATA_WIDTH-1:0]   buf_wr_data,
    input  logic                    buf_free_valid,
    input  logic [BUF_AW:0]         buf_free_words,
    output logic                    m_desc_valid,
    input  logic                    m_desc_ready,
    output logic [PRIO_W+CHAIN_W+TIME_W+LEN_W+FLOW_W+BUF_AW+LEN_W:0] m_desc_data,
    output logic [15:0]             drop_count
);
    localparam int BUF_WORDS = 1 << BUF_AW;
    localparam int FIELD_W   = PRIO_W + CHAIN_W + TIME_W + LEN_W + FLOW_W;
    localparam int DESC_W    = FIELD_W + BUF_AW + LEN_W + 1;
    localparam int PC_W      = $clog2(KEEP_WIDTH + 1);
    localparam int WCNT_W    = $clog2(MAX_PKT_WORDS + 1);
    localparam int FIFO_AW   = $clog2(DESC_DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        DROP   = 2'd2
    } state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            cnt = cnt + PC_W'(keep[i]);
        end
        return cnt;
    endfunction

    state_t                 state_q;
    logic [BUF_AW-1:0]      wr_ptr_q, start_q, start_d;
    logic [BUF_AW:0]        free_q, free_d;
    logic [WCNT_W-1:0]      words_q, words_d;
    logic [LEN_W-1:0]       meas_q, meas_d;
    logic                   trunc_q, trunc_d;
    logic [FIELD_W-1:0]     fields_q, fields_d;
    logic [15:0]            drop_q;
    logic [DESC_W-1:0]      fifo_mem_q [DESC_DEPTH];
    logic [FIFO_AW-1:0]     fifo_wp_q, fifo_rp_q;
    logic [FIFO_AW:0]       fifo_cnt_q;

    logic                   beat_s, idle_s, admit_s, reject_s, latch_s, wr_s, push_s, pop_s;
    logic [PC_W-1:0]        pc_s;
    logic [LEN_W:0]         len_sum_s;
    logic [BUF_AW+1:0]      free_sum_s;
    logic [DESC_W-1:0]      push_data_s;

    // Beat qualification, admission and the next values of the per-packet accumulators
    always_comb begin
        beat_s   = s_axis_tvalid && !rst;
        idle_s   = (state_q == IDLE);
        pc_s     = popcount(s_axis_tkeep);
        // FIFO space is checked at packet start; only one packet is ever in flight, so the
        // space reserved here is still free when its descriptor is pushed.
        admit_s  = idle_s && beat_s
                   && (free_q >= (BUF_AW+1)'(MAX_PKT_WORDS))
                   && (fifo_cnt_q < (FIFO_AW+1)'(DESC_DEPTH));
        reject_s = idle_s && beat_s && !admit_s;
        latch_s  = admit_s || ((state_q == ACCEPT) && beat_s);
        wr_s     = admit_s
                   || ((state_q == ACCEPT) && beat_s && (words_q < WCNT_W'(MAX_PKT_WORDS)));
        push_s   = latch_s && s_axis_tlast;
        pop_s    = (fifo_cnt_q != '0) && m_desc_ready;
        if (idle_s) begin
            words_d   = WCNT_W'(1);
            len_sum_s = (LEN_W+1)'(pc_s);
            trunc_d   = 1'b0;
            fields_d  = {p_desc_flow_id, p_desc_pk_len, p_desc_time, p_desc_chain, p_desc_prio};
            start_d   = wr_ptr_q;
        end else begin
            words_d   = (words_q < WCNT_W'(MAX_PKT_WORDS)) ? words_q + WCNT_W'(1) : words_q;
            len_sum_s = {1'b0, meas_q} + (LEN_W+1)'(pc_s);
            trunc_d   = trunc_q || (words_q >= WCNT_W'(MAX_PKT_WORDS));
            fields_d  = fields_q;
            start_d   = start_q;
        end
        meas_d      = len_sum_s[LEN_W] ? LEN_MAX : len_sum_s[LEN_W-1:0];
        push_data_s = {trunc_d, meas_d, start_d, fields_d};
        free_sum_s  = {1'b0, free_q} - (BUF_AW+2)'(wr_s)
                      + (buf_free_valid ? {1'b0, buf_free_words} : (BUF_AW+2)'(0));
        if (free_sum_s > (BUF_AW+2)'(BUF_WORDS)) begin
            free_d = (BUF_AW+1)'(BUF_WORDS);
        end else begin
            free_d = free_sum_s[BUF_AW:0];
        end
    end

    // Packet FSM, write pointer, free-space accounting and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            free_q   <= (BUF_AW+1)'(BUF_WORDS);
            words_q  <= '0;
            meas_q   <= '0;
            trunc_q  <= 1'b0;
            fields_q <= '0;
            start_q  <= '0;
            drop_q   <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat_s && !s_axis_tlast) begin
                        state_q <= admit_s ? ACCEPT : DROP;
                    end
                end
                ACCEPT, DROP: begin
                    if (beat_s && s_axis_tlast) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (latch_s) begin
                words_q  <= words_d;
                meas_q   <= meas_d;
                trunc_q  <= trunc_d;
                fields_q <= fields_d;
                start_q  <= start_d;
            end
            if (wr_s) begin
                wr_ptr_q <= wr_ptr_q + BUF_AW'(1);
            end
            free_q <= free_d;
            if (reject_s && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Descriptor FIFO; a push into the slot being popped in the same cycle is safe
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_q[fifo_wp_q] <= push_data_s;
                fifo_wp_q             <= fifo_wp_q + FIFO_AW'(1);
            end
            if (pop_s) begin
                fifo_rp_q <= fifo_rp_q + FIFO_AW'(1);
            end
            fifo_cnt_q <= fifo_cnt_q + (FIFO_AW+1)'(push_s) - (FIFO_AW+1)'(pop_s);
        end
    end

    assign s_axis_tready = !rst;
    assign desc_req      = idle_s && beat_s;
    assign desc_next     = admit_s;
    assign buf_wr_en     = wr_s;
    assign buf_wr_addr   = wr_ptr_q;
    assign buf_wr_data   = s_axis_tdata;
    assign m_desc_valid  = (fifo_cnt_q != '0);
    assign m_desc_data   = fifo_mem_q[fifo_rp_q];
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_desc_builder.sv
// Self-checking bench for desc_builder: directed scenarios, a vector table and random traffic,
// all compared cycle by cycle against a packet-level reference model.
`timescale 1ns/1ps
module tb_desc_builder;
    localparam int DW = 256, KW = 32, PRIO_W = 8, CHAIN_W = 32, TIME_W = 16, LEN_W = 16;
    localparam int FLOW_W = 8, BUF_AW = 10, MAXW = 64, DEPTH = 8, BUF_WORDS = 1024;
    localparam int DESC_W = PRIO_W + CHAIN_W + TIME_W + LEN_W + FLOW_W + BUF_AW + LEN_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     tdata = '0;
    logic [KW-1:0]     tkeep = '0;
    logic              tvalid = 1'b0, tlast = 1'b0;
    logic              s_axis_tready, desc_req, desc_next;
    logic [7:0]        p_prio = '0;
    logic [31:0]       p_chain = '0;
    logic [15:0]       p_time = '0, p_pk_len = '0;
    logic [7:0]        p_flow = '0;
    logic              buf_wr_en;
    logic [BUF_AW-1:0] buf_wr_addr;
    logic [DW-1:0]     buf_wr_data;
    logic              free_valid = 1'b0;
    logic [BUF_AW:0]   free_words = '0;
    logic              m_desc_valid;
    logic              m_desc_ready = 1'b0;
    logic [DESC_W-1:0] m_desc_data;
    logic [15:0]       drop_count;

    desc_builder dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tready(s_axis_tready),
        .desc_req(desc_req), .desc_next(desc_next),
        .p_desc_prio(p_prio), .p_desc_chain(p_chain), .p_desc_time(p_time),
        .p_desc_pk_len(p_pk_len), .p_desc_flow_id(p_flow),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_free_valid(free_valid), .buf_free_words(free_words),
        .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready), .m_desc_data(m_desc_data),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef logic [DESC_W-1:0] desc_t;
    desc_t      exp_q[$];
    int         m_mode;       // 0: between packets, 1: storing a packet, 2: discarding a packet
    int         m_words, m_len, m_wr, m_free, m_drops, m_start;
    bit         m_trunc;
    logic [79:0] m_fields;
    bit         rst_prev = 1'b0;

    // per-packet observations used by the directed checks
    int         pkt_req, pkt_next, pkt_writes, first_wr_addr, pop_cnt;
    desc_t      last_pop;
    logic [79:0] b0_fields;
    bit         gaps_en = 1'b0;

    task automatic model_reset();
        exp_q.delete();
        m_mode = 0; m_words = 0; m_len = 0; m_wr = 0; m_free = BUF_WORDS;
        m_drops = 0; m_start = 0; m_trunc = 1'b0; m_fields = '0;
    endtask

    // One clock: compare the DUT against the model at the falling edge, then advance the model.
    task automatic tick();
        bit req_e, adm, wr_e;
        int pc, rel;
        logic [79:0] cur;
        @(negedge clk);
        req_e = !rst && tvalid && (m_mode == 0);
        adm   = req_e && (m_free >= MAXW) && (exp_q.size() < DEPTH);
        wr_e  = adm || (!rst && tvalid && (m_mode == 1) && (m_words < MAXW));
        pc    = $countones(tkeep);
        cur   = {p_flow, p_pk_len, p_time, p_chain, p_prio};
        chk("tready", s_axis_tready, !rst);
        chk("desc_req", desc_req, req_e);
        chk("desc_next", desc_next, adm);
        chk("wr_en", buf_wr_en, wr_e);
        if (wr_e) begin
            chk("wr_addr", buf_wr_addr, m_wr);
            chk("wr_data_lo", buf_wr_data[127:0], tdata[127:0]);
            chk("wr_data_hi", buf_wr_data[255:128], tdata[255:128]);
        end
        if (!rst || rst_prev) begin
            chk("m_valid", m_desc_valid, exp_q.size() != 0);
            if (m_desc_valid && exp_q.size() != 0) chk("m_data", m_desc_data, exp_q[0]);
            chk("drop_count", drop_count, m_drops);
        end
        if (desc_req) pkt_req++;
        if (desc_next) pkt_next++;
        if (buf_wr_en) begin
            if (pkt_writes == 0) first_wr_addr = buf_wr_addr;
            pkt_writes++;
        end
        if (!rst && m_desc_valid && m_desc_ready) begin
            pop_cnt++;
            last_pop = m_desc_data;
        end
        if (rst) begin
            model_reset();
        end else begin
            if (exp_q.size() != 0 && m_desc_ready) void'(exp_q.pop_front());
            if (tvalid) begin
                if (m_mode == 0) begin
                    if (adm) begin
                        m_fields = cur; m_start = m_wr; m_words = 1; m_len = pc; m_trunc = 1'b0;
                        if (tlast) exp_q.push_back({m_trunc, 16'(m_len), 10'(m_start), m_fields});
                        else m_mode = 1;
                    end else begin
                        if (m_drops < 65535) m_drops++;
                        if (!tlast) m_mode = 2;
                    end
                end else if (m_mode == 1) begin
                    if (m_words < MAXW) m_words++;
                    else m_trunc = 1'b1;
                    m_len = (m_len + pc > 65535) ? 65535 : m_len + pc;
                    if (tlast) begin
                        exp_q.push_back({m_trunc, 16'(m_len), 10'(m_start), m_fields});
                        m_mode = 0;
                    end
                end else if (tlast) begin
                    m_mode = 0;
                end
            end
            rel = free_valid ? int'(free_words) : 0;
            if (wr_e) m_wr = (m_wr + 1) % BUF_WORDS;
            m_free = m_free - int'(wr_e) + rel;
            if (m_free > BUF_WORDS) m_free = BUF_WORDS;
        end
        rst_prev = rst;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [KW-1:0] keep_of(input int n);
        logic [KW:0] t;
        t = (33'd1 << n) - 33'd1;
        return t[KW-1:0];
    endfunction

    task automatic rand_side();
        m_desc_ready = ($urandom_range(0, 3) != 0);
        free_valid   = ($urandom_range(0, 4) == 0);
        free_words   = 11'($urandom_range(1, 80));
    endtask

    task automatic drive_beat(input bit last, input int bytes, input int rel);
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            tvalid = 1'b0; tlast = 1'b0; free_valid = 1'b0;
            rand_side();
            tick();
        end
        tvalid = 1'b1; tlast = last; tkeep = keep_of(bytes);
        for (int i = 0; i < 8; i++) tdata[i*32 +: 32] = $urandom;
        p_prio = 8'($urandom); p_chain = $urandom; p_time = 16'($urandom);
        p_pk_len = 16'($urandom); p_flow = 8'($urandom);
        free_valid = (rel > 0); free_words = 11'(rel);
        if (gaps_en && rel == 0) rand_side();
        tick();
    endtask

    task automatic send_pkt(input int nb, input int last_bytes, input int rel_first);
        pkt_req = 0; pkt_next = 0; pkt_writes = 0; first_wr_addr = -1;
        for (int b = 0; b < nb; b++) begin
            drive_beat(b == nb - 1, (b == nb - 1) ? last_bytes : 32, (b == 0) ? rel_first : 0);
            if (b == 0) b0_fields = {p_flow, p_pk_len, p_time, p_chain, p_prio};
        end
        tvalid = 1'b0; tlast = 1'b0; free_valid = 1'b0;
    endtask

    task automatic release_all();
        tvalid = 1'b0; free_valid = 1'b1; free_words = 11'(BUF_WORDS);
        tick();
        free_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; free_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int beats; int last_bytes; int exp_len; bit exp_trunc; int exp_writes;
    } vec_t;
    vec_t vecs[8];

    initial begin
        vecs[0] = '{1, 1, 1, 1'b0, 1};
        vecs[1] = '{1, 32, 32, 1'b0, 1};
        vecs[2] = '{3, 16, 80, 1'b0, 3};
        vecs[3] = '{2, 7, 39, 1'b0, 2};
        vecs[4] = '{64, 32, 2048, 1'b0, 64};
        vecs[5] = '{65, 5, 2053, 1'b1, 64};
        vecs[6] = '{70, 32, 2240, 1'b1, 64};
        vecs[7] = '{5, 31, 159, 1'b0, 5};
        model_reset();

        // 3-beat packet, 80 bytes
        do_reset();
        chk("rst_valid", m_desc_valid, 1'b0);
        chk("rst_drops", drop_count, 16'd0);
        m_desc_ready = 1'b0;
        send_pkt(3, 16, 0);
        chk("t1_req", pkt_req, 1);
        chk("t1_next", pkt_next, 1);
        chk("t1_writes", pkt_writes, 3);
        chk("t1_first_addr", first_wr_addr, 0);
        chk("t1_valid", m_desc_valid, 1'b1);
        chk("t1_len", m_desc_data[105:90], 16'd80);
        chk("t1_addr", m_desc_data[89:80], 10'd0);
        chk("t1_trunc", m_desc_data[106], 1'b0);
        chk("t1_fields", m_desc_data[79:0], b0_fields);

        // two back-to-back single-beat packets
        do_reset();
        m_desc_ready = 1'b0;
        send_pkt(1, 32, 0);
        chk("t2_next_a", pkt_next, 1);
        send_pkt(1, 32, 0);
        chk("t2_next_b", pkt_next, 1);
        pop_cnt = 0;
        m_desc_ready = 1'b1;
        tick();
        chk("t2_addr0", last_pop[89:80], 10'd0);
        chk("t2_len0", last_pop[105:90], 16'd32);
        tick();
        chk("t2_addr1", last_pop[89:80], 10'd1);
        tick(); tick();
        chk("t2_pops", pop_cnt, 2);

        // FIFO full: ninth packet dropped, output stable while stalled
        do_reset();
        m_desc_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_pkt(2, 32, 0);
        chk("t3_next", pkt_next, 0);
        chk("t3_writes", pkt_writes, 0);
        chk("t3_drops", drop_count, 16'd1);
        last_pop = m_desc_data;
        repeat (5) tick();
        chk("t3_stable", m_desc_data, last_pop);
        pop_cnt = 0;
        m_desc_ready = 1'b1;
        repeat (10) tick();
        chk("t3_pops", pop_cnt, 8);

        // buffer nearly full: 63 free words rejects, same-cycle release not yet visible
        do_reset();
        m_desc_ready = 1'b1;
        repeat (15) send_pkt(64, 32, 0);
        send_pkt(1, 32, 0);
        send_pkt(2, 32, 0);
        chk("t4_drop_a", pkt_next, 0);
        chk("t4_drop_a_wr", pkt_writes, 0);
        send_pkt(2, 32, 1);
        chk("t4_drop_b", pkt_next, 0);
        send_pkt(1, 32, 0);
        chk("t4_accept", pkt_next, 1);
        chk("t4_accept_wr", pkt_writes, 1);
        chk("t4_drops", drop_count, 16'd2);

        // oversized packet truncated at 64 words
        do_reset();
        send_pkt(70, 32, 0);
        chk("t5_writes", pkt_writes, 64);
        tick();
        chk("t5_trunc", last_pop[106], 1'b1);
        chk("t5_len", last_pop[105:90], 16'd2240);
        send_pkt(1, 32, 0);
        chk("t5_next_addr", first_wr_addr, 64);

        // ring wrap and reset mid-packet
        do_reset();
        repeat (15) send_pkt(64, 32, 0);
        send_pkt(62, 32, 0);
        release_all();
        send_pkt(4, 32, 0);
        chk("t6_first_addr", first_wr_addr, 1022);
        chk("t6_writes", pkt_writes, 4);
        tick();
        chk("t6_buf_addr", last_pop[89:80], 10'd1022);
        drive_beat(1'b0, 32, 0);
        drive_beat(1'b0, 32, 0);
        rst = 1'b1;
        drive_beat(1'b0, 32, 0);
        tick();
        rst = 1'b0;
        tvalid = 1'b0;
        tick();
        chk("t6_rst_valid", m_desc_valid, 1'b0);
        chk("t6_rst_drops", drop_count, 16'd0);
        send_pkt(1, 32, 0);
        chk("t6_after_addr", first_wr_addr, 0);
        tick();
        chk("t6_after_len", last_pop[105:90], 16'd32);

        // vector table
        do_reset();
        m_desc_ready = 1'b1;
        foreach (vecs[i]) begin
            release_all();
            send_pkt(vecs[i].beats, vecs[i].last_bytes, 0);
            chk("vec_writes", pkt_writes, vecs[i].exp_writes);
            tick();
            chk("vec_len", last_pop[105:90], vecs[i].exp_len);
            chk("vec_trunc", last_pop[106], vecs[i].exp_trunc);
        end

        // random traffic against the model
        do_reset();
        gaps_en = 1'b1;
        for (int n = 0; n < 250; n++) begin
            send_pkt(($urandom_range(0, 9) == 0) ? $urandom_range(60, 72) : $urandom_range(1, 6),
                     $urandom_range(1, 32), 0);
        end
        gaps_en = 1'b0;
        m_desc_ready = 1'b1;
        repeat (12) tick();
        chk("rand_drained", m_desc_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
